sys_pio_out_ext: RTL and testbench

Parametrised Avalon-MM output PIO, next generation of the system's 32-bit output port. Adds configurable width and reset value, a toggle register, and a one-shot pulse engine: selected bits are driven high for a programmable number of clock cycles, then auto-clear and raise a sticky completion interrupt. Sits on the system interconnect as a slave; `out_port` drives board-level signals (injector/ignition strobes, LEDs, enables).

---
 rtl/sys_pio_out_ext_if.sv | 11 +
 rtl/sys_pio_out_ext.sv | 160 ++++++++++++++++
 tb/tb_sys_pio_out_ext.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_pio_out_ext_if.sv
// Avalon-MM slave bus bundle for sys_pio_out_ext: word address, select, active-low write, 32-bit data.
interface sys_pio_out_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sys_pio_out_ext.sv
// Parametrised output PIO with set/clear/toggle and an optional one-shot pulse engine.
// Pulse engine (PULSE_WIDTH/PULSE_MASK/PULSE/EVENT regs, irq) is built only with SYS_PIO_OUT_PULSE_EN.
module sys_pio_out_ext #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
  parameter int                    PULSE_W       = 16,
  parameter logic [PULSE_W-1:0]    PULSE_DEFAULT = PULSE_W'(1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sys_pio_out_ext_if.slave      bus,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_WIDTH  = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_TOGGLE = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLEAR  = 3'd5;
  localparam logic [2:0] A_PULSE  = 3'd6;
  localparam logic [2:0] A_EVENT  = 3'd7;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_wr;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [31:0]           w_rd;
  logic                  w_unused;

  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_wd     = bus.writedata[DATA_WIDTH-1:0];
  assign w_unused = ^bus.writedata;
  assign out_port = r_data;
  assign bus.readdata = w_rd;

  // Plain register-write effect on the data word, before any pulse expiry.
  always_comb begin
    w_data_wr = r_data;
    if (w_wr) begin
      case (bus.address)
        A_DATA:   w_data_wr = w_wd;
        A_TOGGLE: w_data_wr = r_data ^ w_wd;
        A_SET:    w_data_wr = r_data | w_wd;
        A_CLEAR:  w_data_wr = r_data & ~w_wd;
        default:  w_data_wr = r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_data <= RESET_VALUE;
    else          r_data <= w_data_nxt;
  end

`ifdef SYS_PIO_OUT_PULSE_EN
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state, w_state_nxt;
  logic [PULSE_W-1:0]    r_width, w_width_nxt;
  logic [PULSE_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PULSE_W-1:0]    w_reload_val;
  logic [DATA_WIDTH-1:0] r_mask, w_mask_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_reload;

  // A programmed width of 0 behaves as 1 cycle.
  assign w_reload_val = (r_width == '0) ? '0 : r_width - PULSE_W'(1);
  assign irq          = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_width <= PULSE_DEFAULT;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_width <= w_width_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_data_nxt  = w_data_wr;
    w_mask_nxt  = r_mask;
    w_width_nxt = r_width;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    if (w_wr) begin
      case (bus.address)
        A_DATA:  w_mask_nxt = '0;
        A_WIDTH: w_width_nxt = bus.writedata[PULSE_W-1:0];
        A_TOGGLE, A_SET, A_CLEAR: w_mask_nxt = r_mask & ~w_wd;
        A_PULSE: begin
          if (w_wd != '0) begin
            w_data_nxt = w_data_wr | w_wd;
            w_mask_nxt = r_mask | w_wd;
            w_reload   = 1'b1;
          end
        end
        A_EVENT: w_done_nxt = 1'b0;
        default: ;
      endcase
    end
    // A reload on the expiry edge wins; otherwise expiry clears whatever mask survived the write.
    case (r_state)
      S_IDLE: begin
        if (w_reload) begin
          w_cnt_nxt   = w_reload_val;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_reload) begin
          w_cnt_nxt = w_reload_val;
        end else if (r_cnt == '0) begin
          w_data_nxt  = w_data_nxt & ~w_mask_nxt;
          if (w_mask_nxt != '0) w_done_nxt = 1'b1;
          w_mask_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (w_mask_nxt == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - PULSE_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      A_DATA:  w_rd[DATA_WIDTH-1:0] = r_data;
      A_WIDTH: w_rd[PULSE_W-1:0]    = r_width;
      A_MASK:  w_rd[DATA_WIDTH-1:0] = r_mask;
      A_EVENT: w_rd[0]              = r_done;
      default: w_rd = '0;
    endcase
  end
`else
  assign w_data_nxt = w_data_wr;
  assign irq        = 1'b0;

  always_comb begin
    w_rd = '0;
    if (bus.address == A_DATA) w_rd[DATA_WIDTH-1:0] = r_data;
  end
`endif

endmodule

// File: tb/tb_sys_pio_out_ext.sv
// Self-checking bench for sys_pio_out_ext (DATA_WIDTH=8, RESET_VALUE=0xA5); adapts to SYS_PIO_OUT_PULSE_EN.
module tb_sys_pio_out_ext;
`ifdef SYS_PIO_OUT_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
  logic       irq;

  always #5 clk = ~clk;

  sys_pio_out_ext_if bus();

  sys_pio_out_ext #(
    .DATA_WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_W(16), .PULSE_DEFAULT(16'd1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port), .irq(irq)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  exp;
  } vec_t;

  vec_t tv[8];

  // Behavioural reference: pulse end tracked as an absolute edge deadline.
  logic [7:0]  m_data, m_mask;
  logic [15:0] m_width;
  bit          m_done;
  int          m_dl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'b0, m_data};
      3'd1: return PEN ? {16'b0, m_width} : 32'd0;
      3'd2: return PEN ? {24'b0, m_mask} : 32'd0;
      3'd7: return PEN ? {31'b0, m_done} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge(input int e, input bit w, input logic [2:0] a, input logic [31:0] d);
    logic [7:0] w8;
    bit reload, act;
    w8 = d[7:0];
    reload = 1'b0;
    act = (m_mask != 8'd0);
    if (w) begin
      case (a)
        3'd0: begin m_data = w8; m_mask = 8'd0; end
        3'd1: if (PEN) m_width = d[15:0];
        3'd3: begin m_data = m_data ^ w8;  m_mask = m_mask & ~w8; end
        3'd4: begin m_data = m_data | w8;  m_mask = m_mask & ~w8; end
        3'd5: begin m_data = m_data & ~w8; m_mask = m_mask & ~w8; end
        3'd6: if (PEN && w8 != 8'd0) begin
                m_data = m_data | w8; m_mask = m_mask | w8; reload = 1'b1;
              end
        3'd7: if (PEN) m_done = 1'b0;
        default: ;
      endcase
    end
    if (reload) m_dl = e + ((m_width == 16'd0) ? 1 : int'(m_width));
    else if (act && e == m_dl) begin
      if (m_mask != 8'd0) begin
        m_data = m_data & ~m_mask;
        m_done = 1'b1;
      end
      m_mask = 8'd0;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  a;
    logic [31:0] d;
    bit          w;

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    tv[0] = '{3'd0, 32'h000, 8'h00};
    tv[1] = '{3'd4, 32'h00F, 8'h0F};
    tv[2] = '{3'd5, 32'h003, 8'h0C};
    tv[3] = '{3'd3, 32'h0F0, 8'hFC};
    tv[4] = '{3'd4, 32'h100, 8'hFC};
    tv[5] = '{3'd3, 32'h0FF, 8'h03};
    tv[6] = '{3'd5, 32'h0FF, 8'h00};
    tv[7] = '{3'd0, 32'h03C, 8'h3C};

    idle(1);
    chk("in_reset_out", out_port, 8'hA5);
    chk("in_reset_irq", irq, 1'b0);
    reset_n = 1'b1;
    idle(1);
    chk("reset_out", out_port, 8'hA5);
    chk("reset_irq", irq, 1'b0);
    rd(3'd1, r); chk("reset_width", r, PEN ? 32'd1 : 32'd0);
    rd(3'd0, r); chk("reset_rd_data", r, 32'hA5);
    wr(3'd0, 32'h1FF);
    chk("data_trunc_out", out_port, 8'hFF);
    rd(3'd0, r); chk("data_trunc_rd", r, 32'h000000FF);

    for (int i = 0; i < 8; i++) begin
      wr(tv[i].a, tv[i].d);
      chk($sformatf("vec%0d_out", i), out_port, tv[i].exp);
      rd(3'd0, r); chk($sformatf("vec%0d_rd", i), r, {24'b0, tv[i].exp});
    end

`ifdef SYS_PIO_OUT_PULSE_EN
    // Single pulse, W=5
    wr(3'd0, 0); wr(3'd1, 5); wr(3'd6, 32'h01);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("p1_high%0d", i), {out_port, 7'b0, irq}, {8'h01, 8'h00});
      idle(1);
    end
    chk("p1_cleared", out_port, 8'h00);
    chk("p1_irq", irq, 1'b1);
    rd(3'd2, r); chk("p1_mask", r, 32'd0);
    rd(3'd7, r); chk("p1_event", r, 32'd1);
    wr(3'd7, 0);
    chk("p1_irq_clr", irq, 1'b0);

    // Restart extends earlier bits
    wr(3'd6, 32'h01); idle(2); wr(3'd6, 32'h02);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("p2_high%0d", i), {out_port, 7'b0, irq}, {8'h03, 8'h00});
      idle(1);
    end
    chk("p2_cleared", out_port, 8'h00);
    chk("p2_irq", irq, 1'b1);
    wr(3'd7, 0);

    // Partial clear keeps the timer running
    wr(3'd1, 10); wr(3'd6, 32'h03); idle(1); wr(3'd5, 32'h01);
    chk("p3_clear_bit0", out_port, 8'h02);
    idle(7);
    chk("p3_before_exp", {out_port, 7'b0, irq}, {8'h02, 8'h00});
    idle(1);
    chk("p3_expired", out_port, 8'h00);
    chk("p3_irq", irq, 1'b1);
    wr(3'd7, 0);

    // Full clear stops the timer, no done
    wr(3'd6, 32'h03); idle(1); wr(3'd5, 32'h03);
    chk("p4_clear_all", out_port, 8'h00);
    idle(10);
    chk("p4_no_irq", irq, 1'b0);
    rd(3'd2, r); chk("p4_mask", r, 32'd0);

    // Reset mid-pulse
    wr(3'd6, 32'h10); idle(2);
    #2 reset_n = 1'b0;
    #1;
    chk("p5_async_out", out_port, 8'hA5);
    chk("p5_async_irq", irq, 1'b0);
    rd(3'd1, r); chk("p5_width_rst", r, 32'd1);
    rd(3'd2, r); chk("p5_mask_rst", r, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    idle(12);
    chk("p5_after_out", out_port, 8'hA5);
    chk("p5_after_irq", irq, 1'b0);
`else
    wr(3'd0, 32'h0F); wr(3'd6, 32'hF0);
    chk("nopulse_out", out_port, 8'h0F);
    wr(3'd1, 5);
    rd(3'd1, r); chk("nopulse_rd1", r, 32'd0);
    rd(3'd2, r); chk("nopulse_rd2", r, 32'd0);
    rd(3'd6, r); chk("nopulse_rd6", r, 32'd0);
    rd(3'd7, r); chk("nopulse_rd7", r, 32'd0);
    idle(3);
    chk("nopulse_irq", irq, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", out_port, 8'hA5);
    @(negedge clk) reset_n = 1'b1;
`endif

    // Randomized run against the reference model
    #2 reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    m_data = 8'hA5; m_mask = 8'd0; m_width = 16'd1; m_done = 1'b0; m_dl = 0;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      a = 3'($urandom_range(0, 7));
      if (a == 3'd1) d = $urandom_range(0, 4);
      else if ($urandom_range(0, 3) == 0) d = 32'd1 << $urandom_range(0, 7);
      else d = $urandom_range(0, 511);
      bus.address = a; bus.writedata = d;
      bus.chipselect = w; bus.write_n = !w;
      m_edge(i, w, a, d);
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      chk($sformatf("rnd%0d_out", i), out_port, m_data);
      chk($sformatf("rnd%0d_irq", i), irq, PEN ? m_done : 1'b0);
      a = 3'($urandom_range(0, 7));
      rd(a, r);
      chk($sformatf("rnd%0d_rd%0d", i, a), r, m_read(a));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
